seq_shift_add_mult: RTL and testbench

Sequential unsigned N x N shift-and-add multiplier. It is the control and datapath stage wrapped around the team's N-bit carry_lookahead_adder: it feeds the adder one partial-product addition per cycle and consumes each N+1-bit result. Operands arrive and the 2N-bit product leaves through valid/ready handshakes, so the block drops into streaming arithmetic paths. Throughput is one product per N+2 cycles minimum; there is no pipelining across operations.

---
 rtl/arith_pkg.sv | 15 +
 rtl/carry_lookahead_adder.sv | 39 +++
 rtl/seq_shift_add_mult.sv | 87 ++++++++
 tb/tb_seq_shift_add_mult.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer state encoding and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the counter can represent N itself without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// n-bit carry-lookahead adder; result[n] is the carry out.
module carry_lookahead_adder #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic [n:0]   result
);

  logic [n-1:0] g;
  logic [n-1:0] p;
  logic [n:0]   carry;

  // Each carry is built from the generate/propagate terms of all lower bits.
  function automatic logic lookahead(input logic [n-1:0] gv, input logic [n-1:0] pv,
                                     input logic c0, input int upto);
    logic c;
    c = c0;
    for (int j = 0; j <= upto; j++) begin
      c = gv[j] | (pv[j] & c);
    end
    return c;
  endfunction

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_bit
      assign g[gi]         = x[gi] & y[gi];
      assign p[gi]         = x[gi] ^ y[gi];
      assign carry[gi + 1] = lookahead(g, p, cin, gi);
      assign result[gi]    = p[gi] ^ carry[gi];
    end
  endgenerate

  assign result[n] = carry[n];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned NxN shift-and-add multiplier with valid/ready handshakes.
module seq_shift_add_mult
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = cnt_width(N);

  state_t           state_reg;
  logic [N-1:0]     mcand_reg;
  logic [N-1:0]     acc_hi_reg;
  logic [N-1:0]     mq_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2*N-1:0]   product_reg;

  logic [N-1:0]     addend;
  logic [N:0]       sum;
  logic [2*N-1:0]   shift_next;

  assign addend = mq_reg[0] ? mcand_reg : '0;

  carry_lookahead_adder #(.n(N)) u_adder (
    .x      (acc_hi_reg),
    .y      (addend),
    .cin    (1'b0),
    .result (sum)
  );

  // The carry out lands in acc_hi[N-1]; mq[0] has been consumed and drops off.
  assign shift_next = {sum, mq_reg[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      mq_reg      <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= a;
            acc_hi_reg <= '0;
            mq_reg     <= b;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_hi_reg <= shift_next[2*N-1:N];
          mq_reg     <= shift_next[N-1:0];
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            product_reg <= shift_next;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == RUN);
  assign out_valid = (state_reg == DONE);
  assign product   = product_reg;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult with N=4 and hand-computed products.
module tb_seq_shift_add_mult;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int errors = 0;
  int checks = 0;

  seq_shift_add_mult #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation: accept, wait for out_valid, optionally stall, then hand off.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic [2*N-1:0] exp, input int hold, input bit junk);
    int n;
    @(negedge clk);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    @(posedge clk);
    #1;
    check("busy_after_accept", 16'(busy), 16'd1);
    check("in_ready_after_accept", 16'(in_ready), 16'd0);
    if (junk) begin
      a = 4'd9;
      b = 4'd9;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    in_valid = 1'b0;
    check("latency", 16'(n), 16'(N));
    check("product", 16'(product), 16'(exp));
    check("in_ready_in_done", 16'(in_ready), 16'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 16'(out_valid), 16'd1);
      check("hold_product", 16'(product), 16'(exp));
      check("hold_in_ready", 16'(in_ready), 16'd0);
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid_after_handshake", 16'(out_valid), 16'd0);
    check("in_ready_after_handshake", 16'(in_ready), 16'd1);
    check("product_kept", 16'(product), 16'(exp));
    if (junk) begin
      @(posedge clk);
      #1;
      check("no_restart_from_junk", 16'(busy), 16'd0);
    end
    $display("op a=%0d b=%0d product=%0d latency=%0d hold=%0d", ta, tb, product, n, hold);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    #2;
    check("reset_in_ready", 16'(in_ready), 16'd1);
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_product", 16'(product), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'd3, 4'd5, 8'd15, 0, 1'b0);
    do_op(4'd15, 4'd15, 8'hE1, 0, 1'b0);
    do_op(4'd15, 4'd0, 8'd0, 0, 1'b0);
    do_op(4'd0, 4'd9, 8'd0, 0, 1'b0);
    do_op(4'd6, 4'd7, 8'd42, 10, 1'b0);
    do_op(4'd2, 4'd3, 8'd6, 0, 1'b1);

    // Abort mid-RUN: two iterations in, then reset between edges.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd13;
    b        = 4'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_product", 16'(product), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd13, 4'd11, 8'd143, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
